// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy state
// encoding, the default NOP payload and a small helper on the state.
package pipe_pkg;

    // Occupancy of the stage: nothing held, main entry held, main and skid held.
    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_ONE   = 2'd1;
    localparam state_t ST_TWO   = 2'd2;

    // Default bubble instruction injected when the stage is empty or flushed.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // The stage refuses new input only when both slots are occupied.
    function automatic logic state_is_full(input state_t s);
        return (s == ST_TWO);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the stage (instruction, PC+4 and a valid bit).
// A clear returns the slot to the NOP bubble; clear wins over load, and a
// slot that is neither cleared nor loaded keeps its contents.
module pipe_slot #(
    parameter int                 DATA_W    = 32,
    parameter int                 PC_W      = 32,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [PC_W-1:0]   load_pc4,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [PC_W-1:0]   pc4
);

    // Slot contents: bubble on reset/clear, capture on load, otherwise hold.
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            valid <= 1'b0;
            instr <= NOP_VALUE;
            pc4   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc4   <= load_pc4;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a skid slot that keeps
// full throughput under backpressure, a hazard stall and a flush that injects
// a NOP and pulses out_flushed for one cycle.
// Optional build macro PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter int                 PC_W      = 32,
    parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}}
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int                 CNT_W     = 16
`endif
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc4,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc4,
    output logic              out_flushed
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    state_t            state;
    state_t            state_next;
    logic              acc_in;
    logic              acc_out;

    logic              main_load;
    logic              main_clear;
    logic              main_from_skid;
    logic [DATA_W-1:0] main_load_instr;
    logic [PC_W-1:0]   main_load_pc4;

    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_instr;
    logic [PC_W-1:0]   skid_pc4;

    logic              in_ready_q;
    logic              flushed_q;

    assign acc_in  = in_valid & in_ready_q;
    assign acc_out = out_valid & out_ready & ~stall;

    // Decide the next occupancy and which slot moves where; flush overrides all.
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if (flush) begin
            state_next = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc_in) begin
                        main_load  = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc_in && acc_out) begin
                        main_load  = 1'b1;
                    end else if (acc_out) begin
                        main_clear = 1'b1;
                        state_next = ST_EMPTY;
                    end else if (acc_in) begin
                        skid_load  = 1'b1;
                        state_next = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (acc_out) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_next     = ST_ONE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // The main slot refills from skid when draining a full stage, else from input.
    always_comb begin
        main_load_instr = in_instr;
        main_load_pc4   = in_pc4;
        if (main_from_skid) begin
            main_load_instr = skid_instr;
            main_load_pc4   = skid_pc4;
        end
    end

    // Occupancy state, registered ready and the post-flush marker.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
            flushed_q  <= 1'b0;
        end else begin
            state      <= state_next;
            in_ready_q <= ~state_is_full(state_next);
            flushed_q  <= flush;
        end
    end

    pipe_slot #(
        .DATA_W    (DATA_W),
        .PC_W      (PC_W),
        .NOP_VALUE (NOP_VALUE)
    ) u_main (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (main_load),
        .clear      (main_clear),
        .load_instr (main_load_instr),
        .load_pc4   (main_load_pc4),
        .valid      (out_valid),
        .instr      (out_instr),
        .pc4        (out_pc4)
    );

    pipe_slot #(
        .DATA_W    (DATA_W),
        .PC_W      (PC_W),
        .NOP_VALUE (NOP_VALUE)
    ) u_skid (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_instr (in_instr),
        .load_pc4   (in_pc4),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc4        (skid_pc4)
    );

    assign in_ready    = in_ready_q;
    assign out_flushed = flushed_q;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating counts of stalled-valid cycles and flush cycles.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: reset, streaming,
// backpressure through the skid slot, stall, flush and simultaneous accept.
module tb_pipe_stage_reg;

    logic        CLK;
    logic        RESET;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        out_flushed;

    int checks;
    int failures;

    pipe_stage_reg dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc4      (in_pc4),
        .stall       (stall),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc4     (out_pc4),
        .out_flushed (out_flushed)
    );

    // Free-running clock, 10 time units per cycle.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, then advance past the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic ordy, input logic stl, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc4    = pc;
        out_ready = ordy;
        stall     = stl;
        flush     = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc, input logic rdy, input logic fld);
        checkOutput({tag, ".out_valid"},   {31'd0, out_valid},   {31'd0, v});
        checkOutput({tag, ".out_instr"},   out_instr,            ins);
        checkOutput({tag, ".out_pc4"},     out_pc4,              pc);
        checkOutput({tag, ".in_ready"},    {31'd0, in_ready},    {31'd0, rdy});
        checkOutput({tag, ".out_flushed"}, {31'd0, out_flushed}, {31'd0, fld});
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held two cycles with noisy inputs and flush asserted.
        RESET = 1'b1;
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1, 1'b0, 1'b1);
        checkAll("reset", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        RESET = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkAll("idle", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming: two back-to-back words, one-cycle latency, no bubbles.
        applyStimulus(1'b1, 32'h2008_0005, 32'h0000_0004, 1'b1, 1'b0, 1'b0);
        checkAll("stream0", 1'b1, 32'h2008_0005, 32'h0000_0004, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h2009_0007, 32'h0000_0008, 1'b1, 1'b0, 1'b0);
        checkAll("stream1", 1'b1, 32'h2009_0007, 32'h0000_0008, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkAll("stream_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure: A then B fill main and skid, C is refused while full.
        applyStimulus(1'b1, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        checkAll("bp_a", 1'b1, 32'h0000_0001, 32'h0000_0010, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_0002, 32'h0000_0014, 1'b0, 1'b0, 1'b0);
        checkAll("bp_b", 1'b1, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0099, 32'h0000_0099, 1'b0, 1'b0, 1'b0);
        checkAll("bp_full", 1'b1, 32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkAll("bp_deliver_b", 1'b1, 32'h0000_0002, 32'h0000_0014, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkAll("bp_empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall: A held for three cycles despite out_ready, consumed after.
        applyStimulus(1'b1, 32'h0000_000A, 32'h0000_0020, 1'b1, 1'b0, 1'b0);
        checkAll("stall_load", 1'b1, 32'h0000_000A, 32'h0000_0020, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
            checkAll("stall_hold", 1'b1, 32'h0000_000A, 32'h0000_0020, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkAll("stall_release", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall does not block intake: two words land in main and skid.
        applyStimulus(1'b1, 32'h0000_00B1, 32'h0000_0024, 1'b1, 1'b1, 1'b0);
        checkAll("stall_fill0", 1'b1, 32'h0000_00B1, 32'h0000_0024, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_00B2, 32'h0000_0028, 1'b1, 1'b1, 1'b0);
        checkAll("stall_fill1", 1'b1, 32'h0000_00B1, 32'h0000_0024, 1'b0, 1'b0);

        // Flush with skid full and a new word C offered: everything discarded.
        applyStimulus(1'b1, 32'h0000_0003, 32'h0000_0038, 1'b1, 1'b1, 1'b1);
        checkAll("flush_full", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkAll("flush_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Back-to-back flushes with input offered while ready.
        applyStimulus(1'b1, 32'h0000_00C1, 32'h0000_0040, 1'b1, 1'b0, 1'b1);
        checkAll("flush_b2b0", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_00C2, 32'h0000_0044, 1'b1, 1'b0, 1'b1);
        checkAll("flush_b2b1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkAll("flush_b2b_end", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Simultaneous accept: A held, D enters as A leaves.
        applyStimulus(1'b1, 32'h0000_0011, 32'h0000_0050, 1'b0, 1'b0, 1'b0);
        checkAll("simul_a", 1'b1, 32'h0000_0011, 32'h0000_0050, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_0044, 32'h0000_0054, 1'b1, 1'b0, 1'b0);
        checkAll("simul_d", 1'b1, 32'h0000_0044, 32'h0000_0054, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkAll("simul_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register: the next generation of the IF/ID-style stage latch, usable between any two pipeline stages. It carries an instruction word and PC+4, and adds a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, an explicit stall input, and a flush with a one-cycle flushed marker. Flush injects a NOP.

Parameters:
DATA_W, 32, instruction/payload width
PC_W, 32, PC+4 width
NOP_VALUE, {DATA_W{1'b0}}, payload presented when stage is empty or flushed
CNT_W, 16, performance counter width (used only with PIPE_STAGE_PERF_EN)

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous, active-high reset
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept (registered)
in_instr  in  DATA_W  upstream instruction
in_pc4  in  PC_W  upstream PC+4
stall  in  1  hazard stall; blocks downstream transfer while high
flush  in  1  discard all held entries
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_instr  out  DATA_W  main entry instruction
out_pc4  out  PC_W  main entry PC+4
out_flushed  out  1  one-cycle pulse following a flush

Behaviour:
- Reset (RESET high at posedge): state=ST_EMPTY, out_valid=0, out_instr=NOP_VALUE, out_pc4=0, out_flushed=0, in_ready=1, skid cleared. RESET overrides flush and all other inputs.
- acc_in = in_valid & in_ready; acc_out = out_valid & out_ready & ~stall.
- in_ready = ~skid_valid; it is a registered value taken from state.
- States are ST_EMPTY (none held), ST_ONE (main held), ST_TWO (main+skid held).
- ST_EMPTY: on acc_in, main<=in and go to ST_ONE. Latency in->out is 1 cycle.
- ST_ONE:
  - acc_in&acc_out: main<=in and stay in ST_ONE. Throughput is 1/cycle.
  - acc_out only: main<=NOP_VALUE/0 and go to ST_EMPTY.
  - acc_in only: skid<=in and go to ST_TWO.
  - neither: hold.
- ST_TWO: in_ready=0. On acc_out, main<=skid and go to ST_ONE. Otherwise hold. No data loss, no duplication.
- Whenever out_valid=0, out_instr=NOP_VALUE and out_pc4=0.
- flush (not in reset):
  - Next state is ST_EMPTY; main and skid are cleared to NOP_VALUE/0.
  - Any input presented in the flush cycle is discarded, even if in_ready=1.
  - out_flushed=1 for exactly the next cycle, with out_valid=0.
  - in_ready=1 the next cycle.
- flush has priority over stall, acc_in and acc_out.
- Back-to-back flushes keep out_flushed high for every following cycle.
- out_flushed=0 in all other cycles.
- stall with out_ready=1 behaves as out_ready=0. The stage keeps accepting into skid until it is full.
- Payload is never modified, only moved.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined:
  - Adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W].
  - stall_cnt increments each cycle where out_valid&stall.
  - flush_cnt increments each cycle flush=1.
  - Both counters saturate at all-ones and clear on RESET.
- When undefined: the ports and logic are absent; the datapath behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - state typedef (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2)
  - default NOP constant NOP_INSTR=32'h0000_0000
- Sub-module pipe_slot: one payload register (instr+pc4+valid) with load, clear-to-NOP and hold controls. It is instantiated twice, for main and skid.

Test Plan:
- Reset sequence: RESET high 2 cycles with in_valid=1, flush=1 -> out_valid=0, out_instr=0, out_pc4=0, out_flushed=0, in_ready=1.
- Streaming: in_instr=0x20080005, then 0x20090007 on consecutive cycles with out_ready=1 -> each appears on out_instr one cycle later, out_valid high 2 cycles, no bubbles.
- Backpressure: out_ready=0, push A=0x1, B=0x2 -> in_ready falls after B. Raise out_ready -> A then B delivered in order, then out_valid=0, out_instr=NOP_VALUE.
- Stall: stage holds A, stall=1 for 3 cycles with out_ready=1 -> A stays on outputs and is not consumed. After stall falls it is consumed in one cycle.
- Flush with skid full: A and B held, flush=1 while in_valid=1 with C=0x3 -> next cycle out_valid=0, out_flushed=1, in_ready=1. C is never output.
- Simultaneous accept: ST_ONE holding A, acc_in D and acc_out A in the same cycle -> next cycle out_instr=D, state stays ST_ONE, in_ready=1.
